// File: rtl/mac_rx_gmii_front_pkg.sv
// rtl/mac_rx_gmii_front_pkg.sv - shared types and constants for the MAC Rx GMII/MII front-end
package mac_rx_pkg;

  typedef enum logic [2:0] {WAIT_IDLE, IDLE, PREAMBLE, DATA, DROP} rx_state_e;
  typedef enum logic [1:0] {SYM_PRE, SYM_SFD, SYM_BAD} sym_kind_e;

  localparam int ST_RX_ER    = 0;
  localparam int ST_DRIBBLE  = 1;
  localparam int ST_RUNT     = 2;
  localparam int ST_OVERSIZE = 3;
  localparam int ST_CRC_BAD  = 4;

  localparam logic [7:0]  PRE_BYTE    = 8'h55;
  localparam logic [7:0]  SFD_BYTE    = 8'hD5;
  localparam logic [3:0]  PRE_NIB     = 4'h5;
  localparam logic [3:0]  SFD_NIB     = 4'hD;
  localparam logic [31:0] CRC_RESIDUE = 32'hC704DD7B;

  // Preamble symbol class: full byte at 1000M, low nibble only at 100M.
  function automatic sym_kind_e classify(input logic spd, input logic [7:0] d);
    if (spd) begin
      if (d == PRE_BYTE) return SYM_PRE;
      if (d == SFD_BYTE) return SYM_SFD;
    end else begin
      if (d[3:0] == PRE_NIB) return SYM_PRE;
      if (d[3:0] == SFD_NIB) return SYM_SFD;
    end
    return SYM_BAD;
  endfunction

  // The CRC engine shifts LSB first, so its register is the mirror of the MSB-first residue.
  function automatic logic [31:0] bitrev32(input logic [31:0] v);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) r[i] = v[31-i];
    return r;
  endfunction

endpackage

// File: rtl/mac_rx_gmii_front_if.sv
// rtl/mac_rx_gmii_front_if.sv - PHY receive inputs and Rx FIFO byte stream of the front-end
interface mac_rx_gmii_front_if;
  logic        Rx_dv;
  logic        Rx_er;
  logic [7:0]  Rxd;
  logic        Speed;
  logic [7:0]  Rx_data;
  logic        Rx_valid;
  logic        Rx_sof;
  logic        Rx_eof;
  logic [4:0]  Rx_status;
  logic [15:0] Rx_len;
  logic        Frame_drop;

  modport master (
    input  Rx_dv, Rx_er, Rxd, Speed,
    output Rx_data, Rx_valid, Rx_sof, Rx_eof, Rx_status, Rx_len, Frame_drop
  );

  modport slave (
    output Rx_dv, Rx_er, Rxd, Speed,
    input  Rx_data, Rx_valid, Rx_sof, Rx_eof, Rx_status, Rx_len, Frame_drop
  );
endinterface

// File: rtl/mac_crc32_d8.sv
// rtl/mac_crc32_d8.sv - combinational reflected CRC-32 update for one byte
module mac_crc32_d8 (
  input  logic [31:0] crc_in,
  input  logic [7:0]  data_in,
  output logic [31:0] crc_out
);

  // Eight LSB-first shift steps with the reflected polynomial 0xEDB88320.
  always_comb begin
    logic [31:0] c;
    c = crc_in;
    for (int i = 0; i < 8; i++) begin
      c = (c[0] ^ data_in[i]) ? ({1'b0, c[31:1]} ^ 32'hEDB88320) : {1'b0, c[31:1]};
    end
    crc_out = c;
  end

endmodule

// File: rtl/mac_rx_gmii_front.sv
// rtl/mac_rx_gmii_front.sv - GMII/MII receive front-end; optional FCS check under MAC_RX_CRC_CHECK_EN
module mac_rx_gmii_front
  import mac_rx_pkg::*;
#(
  parameter int MIN_LEN = 64,
  parameter int MAX_LEN = 1518
) (
  input logic                 Rx_clk,
  input logic                 Reset_n,
  mac_rx_gmii_front_if.master bus
);

  localparam logic [15:0] MIN_L = 16'(MIN_LEN);
  localparam logic [15:0] MAX_L = 16'(MAX_LEN);

  rx_state_e   state;
  logic        spd;
  logic        nib_have;
  logic [3:0]  nib_lo;
  logic [7:0]  hold_data;
  logic [15:0] cnt;
  logic        er_seen;
  logic        ovf;

  logic        samp_spd;
  sym_kind_e   sym;
  logic [7:0]  new_byte;
  logic        byte_done;
  logic        accept;
  logic        enter_data;
  logic        crc_bad;
  logic [4:0]  eof_status;

  // Symbol decode; the IDLE symbol is judged with the Speed being latched on that same edge.
  always_comb begin
    samp_spd   = (state == IDLE) ? bus.Speed : spd;
    sym        = classify(samp_spd, bus.Rxd);
    new_byte   = spd ? bus.Rxd : {bus.Rxd[3:0], nib_lo};
    byte_done  = spd | nib_have;
    accept     = (state == DATA) && bus.Rx_dv && byte_done && (cnt < MAX_L);
    enter_data = ((state == IDLE) || (state == PREAMBLE)) && bus.Rx_dv && (sym == SYM_SFD);
  end

`ifdef MAC_RX_CRC_CHECK_EN
  logic [31:0] crc;
  logic [31:0] crc_next;

  mac_crc32_d8 u_crc (
    .crc_in  (crc),
    .data_in (new_byte),
    .crc_out (crc_next)
  );

  // Running CRC over every byte that will be delivered, FCS included.
  always_ff @(posedge Rx_clk or negedge Reset_n) begin
    if (!Reset_n)        crc <= '1;
    else if (enter_data) crc <= '1;
    else if (accept)     crc <= crc_next;
  end

  assign crc_bad = ovf | (bitrev32(crc) != CRC_RESIDUE);
`else
  assign crc_bad = 1'b0;
`endif

  // Frame status as it stands when the last byte leaves.
  always_comb begin
    eof_status              = '0;
    eof_status[ST_RX_ER]    = er_seen;
    eof_status[ST_DRIBBLE]  = nib_have;
    eof_status[ST_RUNT]     = (cnt < MIN_L);
    eof_status[ST_OVERSIZE] = ovf;
    eof_status[ST_CRC_BAD]  = crc_bad;
  end

  // Receive FSM: preamble hunt, nibble assembly, one-byte holdback and registered outputs.
  always_ff @(posedge Rx_clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state          <= WAIT_IDLE;
      spd            <= 1'b0;
      nib_have       <= 1'b0;
      nib_lo         <= '0;
      hold_data      <= '0;
      cnt            <= '0;
      er_seen        <= 1'b0;
      ovf            <= 1'b0;
      bus.Rx_data    <= '0;
      bus.Rx_valid   <= 1'b0;
      bus.Rx_sof     <= 1'b0;
      bus.Rx_eof     <= 1'b0;
      bus.Rx_status  <= '0;
      bus.Rx_len     <= '0;
      bus.Frame_drop <= 1'b0;
    end else begin
      bus.Rx_valid   <= 1'b0;
      bus.Rx_sof     <= 1'b0;
      bus.Rx_eof     <= 1'b0;
      bus.Rx_status  <= '0;
      bus.Rx_len     <= '0;
      bus.Frame_drop <= 1'b0;
      case (state)
        WAIT_IDLE: if (!bus.Rx_dv) state <= IDLE;
        IDLE, PREAMBLE: begin
          if (!bus.Rx_dv) begin
            if (state == PREAMBLE) begin
              state          <= DROP;
              bus.Frame_drop <= 1'b1;
            end
          end else begin
            if (state == IDLE) spd <= bus.Speed;
            if (enter_data) begin
              state    <= DATA;
              cnt      <= '0;
              nib_have <= 1'b0;
              er_seen  <= 1'b0;
              ovf      <= 1'b0;
            end else if (sym == SYM_PRE) begin
              state <= PREAMBLE;
            end else begin
              state          <= DROP;
              bus.Frame_drop <= 1'b1;
            end
          end
        end
        DATA: begin
          if (bus.Rx_dv) begin
            if (bus.Rx_er) er_seen <= 1'b1;
            if (!byte_done) begin
              nib_lo   <= bus.Rxd[3:0];
              nib_have <= 1'b1;
            end else begin
              nib_have <= 1'b0;
              if (accept) begin
                if (cnt != '0) begin
                  bus.Rx_valid <= 1'b1;
                  bus.Rx_data  <= hold_data;
                  bus.Rx_sof   <= (cnt == 16'd1);
                end
                hold_data <= new_byte;
                cnt       <= cnt + 16'd1;
              end else begin
                ovf <= 1'b1;
              end
            end
          end else begin
            state <= IDLE;
            if (cnt != '0) begin
              bus.Rx_valid  <= 1'b1;
              bus.Rx_data   <= hold_data;
              bus.Rx_sof    <= (cnt == 16'd1);
              bus.Rx_eof    <= 1'b1;
              bus.Rx_status <= eof_status;
              bus.Rx_len    <= cnt;
            end else begin
              bus.Frame_drop <= 1'b1;
            end
          end
        end
        DROP: if (!bus.Rx_dv) state <= IDLE;
        default: state <= WAIT_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mac_rx_gmii_front.sv
// tb/tb_mac_rx_gmii_front.sv - self-checking bench for mac_rx_gmii_front
module tb_mac_rx_gmii_front;

  localparam int MAX_LEN = 1518;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mac_rx_gmii_front_if bus ();

  mac_rx_gmii_front #(.MIN_LEN(64), .MAX_LEN(MAX_LEN)) dut (
    .Rx_clk  (clk),
    .Reset_n (rst_n),
    .bus     (bus)
  );

  typedef struct {
    bit         spd;
    int         n;
    int         pat;
    bit         bad_pre;
    int         er_idx;
    bit         extra;
    int         gap;
    int         exp_len;
    logic [4:0] exp_st;
    int         exp_drop;
  } vec_t;

  typedef logic [30:0] rec_t;

  rec_t exp_q[$];
  rec_t mon_act;
  rec_t mon_exp;
  int   total = 0;
  int   bad = 0;
  int   drop_seen = 0;
  int   drops_exp = 0;
  vec_t tbl[15];

  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.Frame_drop) drop_seen++;
      if (bus.Rx_valid) begin
        mon_act = {bus.Rx_data, bus.Rx_sof, bus.Rx_eof, bus.Rx_status, bus.Rx_len};
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_byte: got data=%h sof=%b eof=%b st=%h len=%0d, required no byte",
                   mon_act[30:23], mon_act[22], mon_act[21], mon_act[20:16], mon_act[15:0]);
        end else begin
          mon_exp = exp_q.pop_front();
          if (mon_act !== mon_exp) begin
            bad++;
            $display("FAIL rx_byte: got data=%h sof=%b eof=%b st=%h len=%0d, required data=%h sof=%b eof=%b st=%h len=%0d",
                     mon_act[30:23], mon_act[22], mon_act[21], mon_act[20:16], mon_act[15:0],
                     mon_exp[30:23], mon_exp[22], mon_exp[21], mon_exp[20:16], mon_exp[15:0]);
          end
        end
      end
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  task automatic sym(input bit dv, input bit er, input logic [7:0] d, input bit speed);
    @(posedge clk);
    #1;
    bus.Rx_dv = dv;
    bus.Rx_er = er;
    bus.Rxd   = d;
    bus.Speed = speed;
  endtask

  function automatic logic [3:0] rnd4();
    return 4'($urandom_range(0, 15));
  endfunction

  function automatic logic [7:0] pat_byte(input int pat, input int i);
    if (pat == 0) return (i < 6) ? 8'hFF : (i < 12) ? 8'h01 : 8'hA5;
    if (pat == 1) return 8'hFF;
    return 8'($urandom_range(0, 255));
  endfunction

`ifdef MAC_RX_CRC_CHECK_EN
  function automatic logic [31:0] crc_step(input logic [31:0] c, input logic [7:0] d);
    for (int k = 0; k < 8; k++)
      c = (c[0] ^ d[k]) ? ({1'b0, c[31:1]} ^ 32'hEDB88320) : {1'b0, c[31:1]};
    return c;
  endfunction
`endif

  task automatic send_frame(input vec_t v);
    logic [7:0] fb[$];
    logic [4:0] st;
    int nb;
    int npre;
    fb = {};
    for (int i = 0; i < v.n; i++) fb.push_back(pat_byte(v.pat, i));
    nb = (v.n < MAX_LEN) ? v.n : MAX_LEN;
    st = v.exp_st;
`ifdef MAC_RX_CRC_CHECK_EN
    begin
      logic [31:0] c;
      c = '1;
      for (int i = 0; i < nb; i++) c = crc_step(c, fb[i]);
      if (v.n > MAX_LEN || c != 32'hDEBB20E3) st[4] = 1'b1;
    end
`endif
    if (!v.bad_pre) begin
      for (int i = 0; i < nb; i++)
        exp_q.push_back({fb[i], 1'(i == 0), 1'(i == nb - 1), (i == nb - 1) ? st : 5'd0,
                         (i == nb - 1) ? 16'(v.exp_len) : 16'd0});
    end
    drops_exp += v.exp_drop;
    npre = v.spd ? 7 : 15;
    for (int k = 0; k < npre; k++) begin
      if (v.bad_pre && k == 3) break;
      sym(1'b1, 1'b0, v.spd ? 8'h55 : {rnd4(), 4'h5}, (k == 0) ? v.spd : !v.spd);
    end
    if (v.bad_pre) sym(1'b1, 1'b0, v.spd ? 8'h12 : {4'hA, 4'h2}, !v.spd);
    else           sym(1'b1, 1'b0, v.spd ? 8'hD5 : {rnd4(), 4'hD}, !v.spd);
    for (int i = 0; i < v.n; i++) begin
      if (v.spd) begin
        sym(1'b1, i == v.er_idx, fb[i], !v.spd);
      end else begin
        sym(1'b1, i == v.er_idx, {rnd4(), fb[i][3:0]}, !v.spd);
        sym(1'b1, 1'b0, {rnd4(), fb[i][7:4]}, !v.spd);
      end
    end
    if (v.extra) sym(1'b1, 1'b0, {rnd4(), 4'h3}, !v.spd);
    for (int g = 0; g < v.gap; g++) sym(1'b0, 1'b0, 8'h00, v.spd);
    if (v.gap >= 3) begin
      check("frame_queue_empty", exp_q.size(), 0);
      check("frame_drop_count", drop_seen, drops_exp);
    end
  endtask

  initial begin
    //          spd   n     pat bad   er  extra gap len   st     drop
    tbl[0]  = '{1'b1, 64,   0, 1'b0, -1, 1'b0, 4, 64,   5'h00, 0};
    tbl[1]  = '{1'b0, 64,   1, 1'b0, -1, 1'b0, 4, 64,   5'h00, 0};
    tbl[2]  = '{1'b0, 64,   1, 1'b0, -1, 1'b1, 4, 64,   5'h02, 0};
    tbl[3]  = '{1'b1, 20,   2, 1'b1, -1, 1'b0, 4, 0,    5'h00, 1};
    tbl[4]  = '{1'b1, 64,   2, 1'b0,  9, 1'b0, 4, 64,   5'h01, 0};
    tbl[5]  = '{1'b1, 40,   0, 1'b0, -1, 1'b0, 4, 40,   5'h04, 0};
    tbl[6]  = '{1'b1, 1528, 2, 1'b0, -1, 1'b0, 4, 1518, 5'h08, 0};
    tbl[7]  = '{1'b1, 0,    2, 1'b0, -1, 1'b0, 4, 0,    5'h00, 1};
    tbl[8]  = '{1'b1, 1,    2, 1'b0, -1, 1'b0, 1, 1,    5'h04, 0};
    tbl[9]  = '{1'b0, 63,   2, 1'b0, 62, 1'b0, 1, 63,   5'h05, 0};
    tbl[10] = '{1'b1, 65,   2, 1'b0, -1, 1'b0, 1, 65,   5'h00, 0};
    tbl[11] = '{1'b0, 1,    2, 1'b0, -1, 1'b1, 4, 1,    5'h06, 0};
    tbl[12] = '{1'b1, 1518, 2, 1'b0, -1, 1'b0, 4, 1518, 5'h00, 0};
    tbl[13] = '{1'b0, 20,   2, 1'b1, -1, 1'b0, 4, 0,    5'h00, 1};
    tbl[14] = '{1'b0, 0,    2, 1'b0, -1, 1'b1, 4, 0,    5'h00, 1};

    bus.Rx_dv = 1'b0;
    bus.Rx_er = 1'b0;
    bus.Rxd   = 8'h00;
    bus.Speed = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", {bus.Rx_data, bus.Rx_valid, bus.Rx_sof, bus.Rx_eof,
                            bus.Rx_status, bus.Rx_len, bus.Frame_drop}, 0);
    rst_n = 1'b1;
    sym(1'b0, 1'b0, 8'h00, 1'b1);
    sym(1'b0, 1'b0, 8'h00, 1'b1);

    for (int t = 0; t < 15; t++) send_frame(tbl[t]);

    // Reset mid-frame with Rx_dv still high: bytes already released stay, the rest is lost.
    for (int k = 0; k < 7; k++) sym(1'b1, 1'b0, 8'h55, 1'b1);
    sym(1'b1, 1'b0, 8'hD5, 1'b1);
    for (int i = 0; i < 10; i++) begin
      if (i < 9) exp_q.push_back({8'(8'h30 + i), 1'(i == 0), 1'b0, 5'd0, 16'd0});
      sym(1'b1, 1'b0, 8'(8'h30 + i), 1'b1);
    end
    @(posedge clk);
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    bus.Rxd = 8'h77;
    #1;
    check("reset_midframe_outputs", {bus.Rx_data, bus.Rx_valid, bus.Rx_sof, bus.Rx_eof,
                                     bus.Rx_status, bus.Rx_len, bus.Frame_drop}, 0);
    sym(1'b1, 1'b0, 8'h55, 1'b1);
    sym(1'b1, 1'b0, 8'h55, 1'b1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    sym(1'b1, 1'b0, 8'h55, 1'b1);
    sym(1'b1, 1'b0, 8'hD5, 1'b1);
    sym(1'b1, 1'b0, 8'h11, 1'b1);
    sym(1'b1, 1'b0, 8'h22, 1'b1);
    sym(1'b1, 1'b0, 8'h33, 1'b1);
    for (int g = 0; g < 3; g++) sym(1'b0, 1'b0, 8'h00, 1'b1);
    check("after_reset_queue_empty", exp_q.size(), 0);
    check("after_reset_drop_count", drop_seen, drops_exp);
    send_frame(tbl[0]);

    repeat (4) @(posedge clk);
    #1;
    check("final_queue_empty", exp_q.size(), 0);
    check("final_drop_count", drop_seen, drops_exp);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
